// File: rtl/uart_pkg.sv
// uart_pkg: command/reply bytes, responder state encoding and timeout sizing
package uart_pkg;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GET_ADDR   = 3'd1;
  localparam logic [2:0] ST_GET_DATA   = 3'd2;
  localparam logic [2:0] ST_REG_ACC    = 3'd3;
  localparam logic [2:0] ST_TX_SEND    = 3'd4;
  localparam logic [2:0] ST_TX_WAIT_HI = 3'd5;
  localparam logic [2:0] ST_TX_WAIT_LO = 3'd6;
  function automatic int timeout_cycles(longint clk_freq, longint baud, longint bytes);
    return int'(bytes * 64'd10 * clk_freq / baud);
  endfunction
endpackage

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: decodes W/R command frames from UART bytes, drives a register bus, replies via tx
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int TIMEOUT_BYTES = 4,
  parameter int ADDR_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              frame_err,
  output logic              busy
);
  localparam int TIMEOUT = timeout_cycles(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);
  logic [2:0]  state;
  logic [7:0]  cmd;
  logic [31:0] tcnt;
  logic [1:0]  gcnt;
  logic        waiting, expire, overrun;
  assign waiting = state == ST_GET_ADDR || state == ST_GET_DATA;
  // a byte arriving on the expiry cycle takes priority over the timeout
  assign expire  = waiting && !rx_done && tcnt == 32'(TIMEOUT - 1);
  assign overrun = rx_done && state inside {ST_REG_ACC, ST_TX_SEND, ST_TX_WAIT_HI, ST_TX_WAIT_LO};
  assign busy    = state != ST_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      tcnt      <= '0;
      gcnt      <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      reg_wr    <= 1'b0;
      frame_err <= overrun;
      tcnt      <= (rx_done || !waiting) ? '0 : tcnt + 32'd1;
      if (expire) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (rx_done) begin
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              cmd   <= rx_data;
              state <= ST_GET_ADDR;
            end else begin
              frame_err <= 1'b1;
              tx_data   <= RSP_ERR;
              state     <= ST_TX_SEND;
            end
          end
          ST_GET_ADDR: if (rx_done) begin
            reg_addr <= ADDR_W'(rx_data);
            state    <= cmd == CMD_WR ? ST_GET_DATA : ST_REG_ACC;
          end
          ST_GET_DATA: if (rx_done) begin
            reg_wdata <= rx_data;
            reg_wr    <= 1'b1;
            state     <= ST_REG_ACC;
          end
          ST_REG_ACC: begin
            tx_data <= cmd == CMD_WR ? RSP_OK : reg_rdata;
            state   <= ST_TX_SEND;
          end
          ST_TX_SEND: if (!tx_busy) begin
            tx_start <= 1'b1;
            gcnt     <= '0;
            state    <= ST_TX_WAIT_HI;
          end
          // guard: give up waiting for busy after 4 cycles so a silent transmitter cannot hang us
          ST_TX_WAIT_HI: begin
            if (tx_busy) state <= ST_TX_WAIT_LO;
            else if (gcnt == 2'd3) state <= ST_IDLE;
            else gcnt <= gcnt + 2'd1;
          end
          ST_TX_WAIT_LO: if (!tx_busy) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: directed frames against a small transmitter and register-file model
module tb_uart_reg_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       tx_busy, tx_start, reg_wr, frame_err, busy;
  logic [7:0] tx_data, reg_addr, reg_wdata, reg_rdata;
  logic       hold_busy = 1'b0;
  logic [3:0] bcnt;
  logic [7:0] regs [256] = '{default: 8'h00};
  int n_tx = 0, n_wr = 0, n_err = 0;
  logic [7:0] last_tx = '0, last_addr = '0, last_wdata = '0;
  int tests = 0, failed = 0;
  int s_tx, s_wr, s_err;

  always #5 clk = ~clk;

  uart_reg_responder #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .TIMEOUT_BYTES(2), .ADDR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .frame_err(frame_err), .busy(busy)
  );

  assign tx_busy   = hold_busy || bcnt != 4'd0;
  assign reg_rdata = regs[reg_addr];

  always @(posedge clk) begin
    if (rst) bcnt <= '0;
    else if (tx_start) bcnt <= 4'd6;
    else if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
    if (tx_start) begin n_tx <= n_tx + 1; last_tx <= tx_data; end
    if (reg_wr) begin
      n_wr <= n_wr + 1; last_addr <= reg_addr; last_wdata <= reg_wdata;
      regs[reg_addr] <= reg_wdata;
    end
    if (frame_err) n_err <= n_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  task automatic snap();
    s_tx = n_tx; s_wr = n_wr; s_err = n_err;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && bcnt == 4'd0) break;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_reg_wr", {31'd0, reg_wr}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_reg_addr", {24'd0, reg_addr}, 0);
    rst = 1'b0;
    // write frame
    snap();
    send_byte(8'h57); send_byte(8'h05); send_byte(8'hA5);
    check("wr_latency", {31'd0, reg_wr}, 1);
    wait_idle("wr");
    check("wr_count", n_wr - s_wr, 1);
    check("wr_addr", {24'd0, last_addr}, 32'h05);
    check("wr_data", {24'd0, last_wdata}, 32'hA5);
    check("wr_tx_count", n_tx - s_tx, 1);
    check("wr_tx_byte", {24'd0, last_tx}, 32'h4B);
    check("wr_no_err", n_err - s_err, 0);
    // read frame
    snap();
    send_byte(8'h52); send_byte(8'h05);
    wait_idle("rd");
    check("rd_tx_count", n_tx - s_tx, 1);
    check("rd_tx_byte", {24'd0, last_tx}, 32'hA5);
    check("rd_no_wr", n_wr - s_wr, 0);
    // bad command
    snap();
    send_byte(8'h41);
    wait_idle("bad");
    check("bad_err", n_err - s_err, 1);
    check("bad_tx_count", n_tx - s_tx, 1);
    check("bad_tx_byte", {24'd0, last_tx}, 32'h3F);
    // inter-byte timeout (200 cycles)
    snap();
    send_byte(8'h57); send_byte(8'h05);
    repeat (250) @(negedge clk);
    check("to_err", n_err - s_err, 1);
    check("to_no_tx", n_tx - s_tx, 0);
    check("to_no_wr", n_wr - s_wr, 0);
    check("to_idle", {31'd0, busy}, 0);
    // overrun while the reply is in flight
    snap();
    send_byte(8'h52); send_byte(8'h05);
    for (int i = 0; i < 50 && bcnt == 4'd0; i++) @(negedge clk);
    @(negedge clk);
    send_byte(8'h57);
    wait_idle("ovr");
    check("ovr_err", n_err - s_err, 1);
    check("ovr_tx_count", n_tx - s_tx, 1);
    check("ovr_tx_byte", {24'd0, last_tx}, 32'hA5);
    // back-to-back write then read of address 0
    snap();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h3C);
    wait_idle("b2b_wr");
    send_byte(8'h52); send_byte(8'h00);
    wait_idle("b2b_rd");
    check("b2b_wr_count", n_wr - s_wr, 1);
    check("b2b_tx_count", n_tx - s_tx, 2);
    check("b2b_tx_byte", {24'd0, last_tx}, 32'h3C);
    // transmitter busy before the reply delays tx_start
    snap();
    hold_busy = 1'b1;
    send_byte(8'h52); send_byte(8'h05);
    repeat (20) @(negedge clk);
    check("hold_no_tx", n_tx - s_tx, 0);
    check("hold_busy", {31'd0, busy}, 1);
    hold_busy = 1'b0;
    wait_idle("hold");
    check("hold_tx_count", n_tx - s_tx, 1);
    check("hold_tx_byte", {24'd0, last_tx}, 32'hA5);
    // reset in GET_DATA, then a normal read
    snap();
    send_byte(8'h57); send_byte(8'h05);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_idle", {31'd0, busy}, 0);
    send_byte(8'h52); send_byte(8'h00);
    wait_idle("post_rst");
    check("post_rst_no_wr", n_wr - s_wr, 0);
    check("post_rst_tx_count", n_tx - s_tx, 1);
    check("post_rst_tx_byte", {24'd0, last_tx}, 32'h3C);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
